// File: rtl/mux_arb_nc1_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer (mux_arb_nc1).
// Package name is mux_pkg; imported by the arbiter and the top.
package mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mux_arb_nc1_arbiter.sv
// Combinational N-way arbiter: fixed priority (ch0 highest) or round robin
// starting at ptr and wrapping N-1 -> 0. Outputs a one-hot grant and its index.
module mux_arbiter
    import mux_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic found_s;
    int   idx_s;

    // Scan channels from the start point and grant the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < N; i++) begin
            if (ARB_MODE == ARB_RR) begin
                idx_s = (int'(ptr) + i) % N;
            end else begin
                idx_s = i;
            end
            if (!found_s && req[idx_s]) begin
                found_s     = 1'b1;
                gnt[idx_s]  = 1'b1;
                gnt_idx     = idx_s[SEL_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nc1.sv
// N-input WIDTH-bit arbitrating multiplexer with valid/ready handshake and a
// one-entry registered output stage. Optional grant locking for atomic bursts
// is enabled by defining MUX_ARB_LOCK_EN.
module mux_arb_nc1
    import mux_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int WIDTH    = 32,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic [N-1:0]       in_lock
`endif
);

    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SEL_W-1:0]   out_sel_r;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [N-1:0]       req_s;
    logic [N-1:0]       gnt_s;
    logic [SEL_W-1:0]   gnt_idx_s;
    logic               slot_free_s;
    logic               xfer_s;
    logic [SEL_W-1:0]   rr_ptr_next_s;

`ifdef MUX_ARB_LOCK_EN
    logic               locked_r;
    logic [SEL_W-1:0]   lock_ch_r;
    logic [N-1:0]       lock_mask_s;

    // While locked only the pinned channel may compete, even if it is idle.
    always_comb begin
        lock_mask_s = '0;
        if (locked_r) begin
            lock_mask_s[lock_ch_r] = 1'b1;
        end else begin
            lock_mask_s = '1;
        end
        req_s = in_valid & lock_mask_s;
    end

    // Lock follows the in_lock bit of each transferring channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r  <= 1'b0;
            lock_ch_r <= '0;
        end else if (xfer_s) begin
            locked_r  <= in_lock[gnt_idx_s];
            lock_ch_r <= gnt_idx_s;
        end else begin
            locked_r  <= locked_r;
            lock_ch_r <= lock_ch_r;
        end
    end
`else
    // Without locking every valid channel competes on every cycle.
    always_comb begin
        req_s = in_valid;
    end
`endif

    mux_arbiter #(
        .N        (N),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .req     (req_s),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Handshake: accept only when the output slot is empty or draining.
    always_comb begin
        slot_free_s = ~out_valid_r | out_ready;
        in_ready    = gnt_s & {N{slot_free_s}};
        xfer_s      = |(in_valid & in_ready);
        if (gnt_idx_s == SEL_W'(N - 1)) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = gnt_idx_s + SEL_W'(1);
        end
    end

    // Output register: load on transfer, clear valid on a bare pop, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_sel_r   <= gnt_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end
    end

    // Round-robin pointer moves past the winner on each transfer only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (xfer_s) begin
            rr_ptr_r <= rr_ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_arb_nc1.sv
// Directed bench for mux_arb_nc1: a round-robin and a fixed-priority instance
// share the same stimulus; expected values are hand-computed constants.
module tb_mux_arb_nc1;

    localparam int N     = 4;
    localparam int WIDTH = 32;

    localparam logic [31:0] D0 = 32'hA000_000A;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic               out_ready;

    logic [N-1:0]       rr_in_ready;
    logic               rr_out_valid;
    logic [WIDTH-1:0]   rr_out_data;
    logic [1:0]         rr_out_sel;

    logic [N-1:0]       fx_in_ready;
    logic               fx_out_valid;
    logic [WIDTH-1:0]   fx_out_data;
    logic [1:0]         fx_out_sel;

`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]       in_lock;
`endif

    int errors = 0;
    int checks = 0;

    mux_arb_nc1 #(.N(N), .WIDTH(WIDTH), .ARB_MODE(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rr_in_ready),
        .in_data   (in_data),
        .out_valid (rr_out_valid),
        .out_ready (out_ready),
        .out_data  (rr_out_data),
        .out_sel   (rr_out_sel)
`ifdef MUX_ARB_LOCK_EN
        ,
        .in_lock   (in_lock)
`endif
    );

    mux_arb_nc1 #(.N(N), .WIDTH(WIDTH), .ARB_MODE(0)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (fx_in_ready),
        .in_data   (in_data),
        .out_valid (fx_out_valid),
        .out_ready (out_ready),
        .out_data  (fx_out_data),
        .out_sel   (fx_out_sel)
`ifdef MUX_ARB_LOCK_EN
        ,
        .in_lock   (in_lock)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {D3, D2, D1, D0};
`ifdef MUX_ARB_LOCK_EN
        in_lock   = 4'b0000;
`endif

        // Reset state
        #1;
        check("rst_out_valid", rr_out_valid, 1'b0);
        check("rst_out_data",  rr_out_data, 32'h0);
        check("rst_out_sel",   rr_out_sel, 2'd0);
        check("rst_in_ready",  rr_in_ready, 4'b0000);
        tick();
        rst_n = 1'b1;

        // Fixed priority: ch1 beats ch3 and keeps winning while valid
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        check("fx_rdy_ch1", fx_in_ready, 4'b0010);
        check("rr_rdy_ch1", rr_in_ready, 4'b0010);
        tick();
        check("fx_sel_ch1",   fx_out_sel, 2'd1);
        check("fx_data_ch1",  fx_out_data, D1);
        check("fx_valid_ch1", fx_out_valid, 1'b1);
        check("fx_rdy_again", fx_in_ready, 4'b0010);
        check("rr_rdy_ch3",   rr_in_ready, 4'b1000);
        tick();
        check("fx_sel_hold_ch1", fx_out_sel, 2'd1);
        check("rr_sel_ch3",      rr_out_sel, 2'd3);
        check("rr_data_ch3",     rr_out_data, D3);

        // Pop with no new transfer: valid drops, data/sel hold
        in_valid = 4'b0000;
        tick();
        check("pop_valid", rr_out_valid, 1'b0);
        check("pop_data",  rr_out_data, D3);
        check("pop_sel",   rr_out_sel, 2'd3);

        // Round robin with all valid: 0,1,2,3,0,1,2,3 one beat per cycle
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr_rdy_%0d", i), rr_in_ready, 4'b0001 << (i % 4));
            tick();
            check($sformatf("rr_sel_%0d", i), rr_out_sel, i % 4);
            check($sformatf("rr_vld_%0d", i), rr_out_valid, 1'b1);
        end
        check("rr_data_last", rr_out_data, D3);

        // Back-pressure: no accept, output stable
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_rr_rdy_%0d", i), rr_in_ready, 4'b0000);
            check($sformatf("bp_fx_rdy_%0d", i), fx_in_ready, 4'b0000);
            tick();
            check($sformatf("bp_data_%0d", i),  rr_out_data, D3);
            check($sformatf("bp_valid_%0d", i), rr_out_valid, 1'b1);
        end
        // Release with ch2 valid: pop and reload together
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        #1;
        check("bp_rel_rdy", rr_in_ready, 4'b0100);
        tick();
        check("bp_rel_valid", rr_out_valid, 1'b1);
        check("bp_rel_sel",   rr_out_sel, 2'd2);
        check("bp_rel_data",  rr_out_data, D2);

        // RR wrap: pointer is 3, ch0 and ch3 valid
        in_valid = 4'b1001;
        #1;
        check("wrap_rdy_ch3", rr_in_ready, 4'b1000);
        tick();
        check("wrap_sel_ch3", rr_out_sel, 2'd3);
        check("wrap_rdy_ch0", rr_in_ready, 4'b0001);
        tick();
        check("wrap_sel_ch0", rr_out_sel, 2'd0);
        in_valid = 4'b1111;
        #1;
        check("wrap_ptr_is_1", rr_in_ready, 4'b0010);
        tick();
        check("wrap_sel_ch1", rr_out_sel, 2'd1);

        // Asynchronous reset mid-run while holding a valid beat
        in_valid = 4'b0000;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", rr_out_valid, 1'b0);
        check("arst_data",  rr_out_data, 32'h0);
        check("arst_sel",   rr_out_sel, 2'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        #1;
        check("arst_ptr_0", rr_in_ready, 4'b0001);
        in_valid = 4'b0000;
        tick();
        check("arst_no_xfer", rr_out_valid, 1'b0);

`ifdef MUX_ARB_LOCK_EN
        // Lock: ch2 pinned across beats, then released
        in_valid = 4'b0100;
        in_lock  = 4'b0100;
        tick();
        check("lk_first_sel", rr_out_sel, 2'd2);
        in_valid = 4'b0111;
        #1;
        check("lk_rdy_a", rr_in_ready, 4'b0100);
        tick();
        check("lk_sel_a", rr_out_sel, 2'd2);
        in_valid = 4'b0011;
        #1;
        check("lk_idle_rdy", rr_in_ready, 4'b0000);
        in_valid = 4'b0111;
        #1;
        check("lk_rdy_b", rr_in_ready, 4'b0100);
        tick();
        check("lk_sel_b", rr_out_sel, 2'd2);
        in_lock = 4'b0000;
        tick();
        check("lk_rel_sel", rr_out_sel, 2'd2);
        in_valid = 4'b0011;
        #1;
        check("lk_after_rdy", rr_in_ready, 4'b0001);
        in_valid = 4'b0000;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
